// File: rtl/periph_bus_arbiter_if.sv
// periph_bus_arbiter_if: bundle of the two master ports and the peripheral strobe port
//   m0_* / m1_* : req, wr, addr, wdata from each master; gnt, ack, err, rdata back to it
//   rd, wr, addr, wdata : strobe bus toward the peripheral; rdata returned combinationally
//   modport slave  : the arbiter's view
//   modport master : the environment's view (both masters and the peripheral)
interface periph_bus_arbiter_if;
    logic        m0_req;
    logic        m0_wr;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic        m1_wr;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rdata;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wdata,
        output m0_gnt, m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_wr, m1_addr, m1_wdata,
        output m1_gnt, m1_ack, m1_err, m1_rdata,
        output rd, wr, addr, wdata,
        input  rdata
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wdata,
        input  m0_gnt, m0_ack, m0_err, m0_rdata,
        output m1_req, m1_wr, m1_addr, m1_wdata,
        input  m1_gnt, m1_ack, m1_err, m1_rdata,
        input  rd, wr, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: round-robin arbiter of two masters onto one peripheral strobe bus
//   sysclk : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : periph_bus_arbiter_if.slave (master handshakes and peripheral strobes)
// Every transaction takes IDLE -> ACCESS -> RESP; all outputs are registered.
module periph_bus_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter logic [31:0] TOP_ADDR  = 32'h40000020,
    parameter logic [31:0] PROT_TOP  = 32'h40000008
) (
    input logic                 sysclk,
    input logic                 reset,
    periph_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_n;
    logic        last, last_n;
    logic        sel, sel_n;
    logic        legal, legal_n;
    logic        rd_q, rd_n;
    logic        wr_q, wr_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic        gnt0, gnt0_n, gnt1, gnt1_n;
    logic        ack0, ack0_n, ack1, ack1_n;
    logic        err0, err0_n, err1, err1_n;
    logic [31:0] rdata0, rdata0_n, rdata1, rdata1_n;

    logic        any_req;
    logic        pick;
    logic        p_wr;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_legal;

    // On a tie the master not served last wins; a sole requester always wins.
    assign any_req = bus.m0_req | bus.m1_req;
    assign pick    = (bus.m0_req & bus.m1_req) ? ~last : bus.m1_req;
    assign p_wr    = pick ? bus.m1_wr    : bus.m0_wr;
    assign p_addr  = pick ? bus.m1_addr  : bus.m0_addr;
    assign p_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
    // Master 1 may not write the timer registers at the bottom of the window.
    assign p_legal = (p_addr >= BASE_ADDR) && (p_addr <= TOP_ADDR) && (p_addr[1:0] == 2'b00)
                     && !(pick && p_wr && (p_addr <= PROT_TOP));

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            sel     <= 1'b0;
            legal   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            sel     <= sel_n;
            legal   <= legal_n;
            rd_q    <= rd_n;
            wr_q    <= wr_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            gnt0    <= gnt0_n;
            gnt1    <= gnt1_n;
            ack0    <= ack0_n;
            ack1    <= ack1_n;
            err0    <= err0_n;
            err1    <= err1_n;
            rdata0  <= rdata0_n;
            rdata1  <= rdata1_n;
        end
    end

    always_comb begin
        state_n = (state == IDLE)   ? (any_req ? ACCESS : IDLE) :
                  (state == ACCESS) ? RESP : IDLE;
    end

    // Next values of the registered outputs. The strobe is decided at the
    // IDLE edge so that it is a flop output during the ACCESS cycle.
    always_comb begin
        last_n   = last;
        sel_n    = sel;
        legal_n  = legal;
        rd_n     = 1'b0;
        wr_n     = 1'b0;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        gnt0_n   = gnt0;
        gnt1_n   = gnt1;
        ack0_n   = 1'b0;
        ack1_n   = 1'b0;
        err0_n   = 1'b0;
        err1_n   = 1'b0;
        rdata0_n = '0;
        rdata1_n = '0;
        if (state == IDLE) begin
            if (any_req) begin
                last_n  = pick;
                sel_n   = pick;
                legal_n = p_legal;
                rd_n    = p_legal & ~p_wr;
                wr_n    = p_legal & p_wr;
                addr_n  = p_legal ? p_addr  : addr_q;
                wdata_n = p_legal ? p_wdata : wdata_q;
                gnt0_n  = ~pick;
                gnt1_n  = pick;
            end
        end else if (state == ACCESS) begin
            ack0_n   = ~sel;
            ack1_n   = sel;
            err0_n   = ~sel & ~legal;
            err1_n   = sel & ~legal;
            rdata0_n = (~sel & rd_q) ? bus.rdata : '0;
            rdata1_n = (sel & rd_q)  ? bus.rdata : '0;
        end else begin
            gnt0_n = 1'b0;
            gnt1_n = 1'b0;
        end
    end

    assign bus.rd       = rd_q;
    assign bus.wr       = wr_q;
    assign bus.addr     = addr_q;
    assign bus.wdata    = wdata_q;
    assign bus.m0_gnt   = gnt0;
    assign bus.m1_gnt   = gnt1;
    assign bus.m0_ack   = ack0;
    assign bus.m1_ack   = ack1;
    assign bus.m0_err   = err0;
    assign bus.m1_err   = err1;
    assign bus.m0_rdata = rdata0;
    assign bus.m1_rdata = rdata1;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: directed self-checking bench for periph_bus_arbiter
module tb_periph_bus_arbiter;
    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] periph_val = 32'h000000A5;

    always #5 sysclk = ~sysclk;

    periph_bus_arbiter_if bus();

    // Peripheral returns a poison value when not strobed, so a capture outside a read shows up.
    assign bus.rdata = bus.rd ? periph_val : 32'hFFFF_FFFF;

    periph_bus_arbiter dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive(input bit m, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (m) begin
            bus.m1_req = r; bus.m1_wr = w; bus.m1_addr = a; bus.m1_wdata = d;
        end else begin
            bus.m0_req = r; bus.m0_wr = w; bus.m0_addr = a; bus.m0_wdata = d;
        end
    endtask

    // One complete transaction from an IDLE cycle: strobe next cycle, ack the one after.
    task automatic xact(input string tag, input bit m, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic ok, input logic [31:0] exp_rd);
        drive(m, 1'b1, w, a, d);
        step();
        check({tag, "_strobe"},   w ? bus.wr : bus.rd, {31'd0, ok});
        check({tag, "_other_st"}, w ? bus.rd : bus.wr, 0);
        check({tag, "_gnt"},      m ? bus.m1_gnt : bus.m0_gnt, 1);
        check({tag, "_ogrant"},   m ? bus.m0_gnt : bus.m1_gnt, 0);
        if (ok) begin
            check({tag, "_addr"}, bus.addr, a);
            if (w) check({tag, "_wdata"}, bus.wdata, d);
        end
        step();
        check({tag, "_ack"},    m ? bus.m1_ack : bus.m0_ack, 1);
        check({tag, "_err"},    m ? bus.m1_err : bus.m0_err, {31'd0, ~ok});
        check({tag, "_rdata"},  m ? bus.m1_rdata : bus.m0_rdata, exp_rd);
        check({tag, "_oack"},   m ? bus.m0_ack : bus.m1_ack, 0);
        check({tag, "_nostr"},  {30'd0, bus.rd, bus.wr}, 0);
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check({tag, "_ackdone"}, m ? bus.m1_ack : bus.m0_ack, 0);
        check({tag, "_gntdone"}, {30'd0, bus.m0_gnt, bus.m1_gnt}, 0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        check("rst_rd",    bus.rd, 0);
        check("rst_wr",    bus.wr, 0);
        check("rst_addr",  bus.addr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_gnt",   {30'd0, bus.m0_gnt, bus.m1_gnt}, 0);
        check("rst_ack",   {30'd0, bus.m0_ack, bus.m1_ack}, 0);
        check("rst_err",   {30'd0, bus.m0_err, bus.m1_err}, 0);
        check("rst_rdata", bus.m0_rdata | bus.m1_rdata, 0);
        reset = 1'b0;
        step();
        check("idle_gnt", {30'd0, bus.m0_gnt, bus.m1_gnt}, 0);

        xact("rd_single", 1'b0, 1'b0, 32'h40000010, 32'h0, 1'b1, 32'h000000A5);
        check("addr_hold", bus.addr, 32'h40000010);
        xact("m1_prot",   1'b1, 1'b1, 32'h40000008, 32'h1, 1'b0, 32'h0);
        xact("m0_prot",   1'b0, 1'b1, 32'h40000008, 32'h1, 1'b1, 32'h0);
        xact("m1_abvprot",1'b1, 1'b1, 32'h4000000C, 32'h5A, 1'b1, 32'h0);
        xact("m1_rdprot", 1'b1, 1'b0, 32'h40000008, 32'h0, 1'b1, 32'h000000A5);
        xact("m1_wrbase", 1'b1, 1'b1, 32'h40000000, 32'h7, 1'b0, 32'h0);
        xact("ill_high",  1'b0, 1'b0, 32'h40000024, 32'h0, 1'b0, 32'h0);
        xact("ill_align", 1'b0, 1'b0, 32'h40000012, 32'h0, 1'b0, 32'h0);
        xact("ill_low",   1'b0, 1'b0, 32'h3FFFFFFC, 32'h0, 1'b0, 32'h0);
        xact("top_ok",    1'b0, 1'b0, 32'h40000020, 32'h0, 1'b1, 32'h000000A5);
        xact("base_ok",   1'b1, 1'b0, 32'h40000000, 32'h0, 1'b1, 32'h000000A5);

        // Tie after reset: m0 first, then alternation, acks at cycles 2, 5, 8, 11.
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h40000004, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h40000014, 32'h0);
        for (int k = 1; k <= 11; k++) begin
            step();
            check($sformatf("rr_ack0_c%0d", k), bus.m0_ack, {31'd0, (k == 2 || k == 8)});
            check($sformatf("rr_ack1_c%0d", k), bus.m1_ack, {31'd0, (k == 5 || k == 11)});
            check($sformatf("rr_excl_c%0d", k), bus.m0_gnt & bus.m1_gnt, 0);
            if (k == 11) begin
                drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        step();
        check("rr_end_gnt", {30'd0, bus.m0_gnt, bus.m1_gnt}, 0);

        // Reset during ACCESS of an m1 write drops the strobe and the ack.
        drive(1'b1, 1'b1, 1'b1, 32'h40000010, 32'h33);
        step();
        check("mid_wr", bus.wr, 1);
        reset = 1'b1;
        step();
        check("mid_wr_drop", bus.wr, 0);
        check("mid_ack",     {30'd0, bus.m0_ack, bus.m1_ack}, 0);
        check("mid_gnt",     {30'd0, bus.m0_gnt, bus.m1_gnt}, 0);
        check("mid_addr",    bus.addr, 0);
        check("mid_wdata",   bus.wdata, 0);
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h40000018, 32'h0);
        step();
        check("post_gnt0", bus.m0_gnt, 1);
        check("post_gnt1", bus.m1_gnt, 0);
        check("post_ack1", bus.m1_ack, 0);
        step();
        check("post_ack0", bus.m0_ack, 1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // m0 drops req in its ACCESS cycle: one ack, no second grant.
        drive(1'b0, 1'b1, 1'b0, 32'h4000001C, 32'h0);
        step();
        check("drop_gnt", bus.m0_gnt, 1);
        drive(1'b0, 1'b0, 1'b0, 32'h4000001C, 32'h0);
        step();
        check("drop_ack", bus.m0_ack, 1);
        step();
        check("drop_ack_once", bus.m0_ack, 0);
        step();
        check("drop_no_regrant", {30'd0, bus.m0_gnt, bus.m1_gnt}, 0);
        check("drop_no_strobe",  {30'd0, bus.rd, bus.wr}, 0);
        step();
        check("drop_no_ack", {30'd0, bus.m0_ack, bus.m1_ack}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 Parameter line: BASE_ADDR, 32'h40000000, lowest legal peripheral word address.
REQ-002 Parameter line: TOP_ADDR, 32'h40000020, highest legal peripheral word address.
REQ-003 Parameter line: PROT_TOP, 32'h40000008, highest address master 1 is forbidden to write (timer registers).
REQ-004 The clock and reset ports SHALL be: sysclk  in  1  single clock, all logic on rising edge; reset  in  1  synchronous, active-high.
REQ-005 The master 0 (CPU) ports SHALL be: m0_req in 1 request; m0_wr in 1 write(1)/read(0); m0_addr in 32; m0_wdata in 32; m0_gnt out 1; m0_ack out 1 one-cycle completion pulse; m0_err out 1 valid with ack; m0_rdata out 32 valid with ack.
REQ-006 The master 1 (UART/DMA engine) ports SHALL mirror master 0 with the m1_ prefix.
REQ-007 The peripheral-side ports SHALL be: rd out 1; wr out 1; addr out 32; wdata out 32; rdata in 32, combinational from the peripheral in the strobe cycle.

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-009 In IDLE with any req high, the arbiter SHALL select one master, register its wr/addr/wdata, and enter ACCESS next cycle; with no req it SHALL stay in IDLE.
REQ-010 Arbitration SHALL be round-robin: when both request, the master not served last wins; the last-served pointer SHALL reset to master 1, so master 0 wins the first tie.
REQ-011 A sole requester SHALL be granted regardless of the pointer; the pointer SHALL update only on grant.
REQ-012 In ACCESS, for a legal access the arbiter SHALL assert exactly one of rd/wr for exactly one cycle, driving addr/wdata from the registered values, and SHALL capture rdata (reads) at the end of that cycle.
REQ-013 An access SHALL be illegal if addr < BASE_ADDR, addr > TOP_ADDR, addr[1:0] != 0, or (master 1 AND write AND addr <= PROT_TOP).
REQ-014 For an illegal access, rd and wr SHALL stay low in ACCESS, captured data SHALL be 0, and err SHALL be set.
REQ-015 In RESP, the granted master's ack SHALL pulse high for one cycle with rdata (0 for writes) and err; the other master's ack, err, and rdata SHALL be 0. The FSM SHALL then enter IDLE unconditionally.
REQ-016 The granted master's gnt SHALL be high in ACCESS and RESP and low in IDLE; m0_gnt and m1_gnt SHALL never both be high.
REQ-017 Latency SHALL be fixed: req sampled in IDLE at cycle N -> strobe at N+1 -> ack at N+2. Peak throughput SHALL be one transaction per 3 cycles.
REQ-018 A master SHALL hold req and its command stable until ack; once granted, the transaction SHALL complete with ack even if req drops.
REQ-019 A req still high in the ack cycle SHALL NOT be re-sampled until the following IDLE cycle.
REQ-020 rd, wr, ack, and gnt SHALL all be registered outputs, with no combinational path from any req to them.
REQ-021 When neither rd nor wr is asserted, addr and wdata SHALL hold their last value; the peripheral ignores them.

Reset
REQ-022 When reset is high at a clock edge, the block SHALL enter IDLE and clear rd, wr, addr, wdata, both gnt, ack, err, and rdata to 0, and set the pointer to master 1.
REQ-023 Reset during ACCESS or RESP SHALL abort the transaction: no ack is issued, and any strobe in flight is dropped in the next cycle.
REQ-024 On the first edge after reset is released, arbitration SHALL begin from IDLE.

Verification
REQ-025 Single read: m0 reads 32'h40000010 with peripheral rdata=32'h000000A5 -> rd high at cycle N+1 only; m0_ack=1, m0_rdata=32'hA5, m0_err=0 at N+2.
REQ-026 Tie round-robin: both masters request continuously after reset -> grant order m0, m1, m0, m1, with acks at cycles 2, 5, 8, 11 after the first request cycle.
REQ-027 Protection: m1 writes 32'h1 to 32'h40000008 -> wr never asserted; m1_ack=1, m1_err=1. The same write from m0 -> wr high, err=0.
REQ-028 Illegal address: m0 reads 32'h40000024, then 32'h40000012 -> no rd strobe for either; err=1 and rdata=0 on both acks.
REQ-029 Reset mid-transaction: reset asserted during ACCESS of an m1 write -> the next cycle has wr=0, no m1_ack, and all outputs 0; after release, the first tie goes to m0.
REQ-030 Dropped request: m0 deasserts req in its ACCESS cycle -> m0_ack still pulses once; no second grant follows.
